half_adder_reg: RTL and testbench

- Lane-parallel half adder. WIDTH independent 1-bit lanes, each computing sum = A xor B and carry = A and B.
- Combinational results are always available on S and C with zero latency.
- A registered, valid-qualified copy is provided for pipelined datapaths.
- Sits at the leaf arithmetic level and is instantiated by adders and counters that need a bitwise sum/carry pair.

---
 rtl/half_adder_reg.sv | 114 +++++++++++
 tb/tb_half_adder_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/half_adder_reg.sv
// half_adder_reg: lane-parallel half adder with a valid-qualified registered copy.
//
// Each of WIDTH independent lanes computes sum = A ^ B and carry = A & B.
// S/C are combinational (zero latency, independent of clk/rst_n/in_valid);
// S_q/C_q/any_carry_q capture the result one cycle after in_valid, and
// out_valid marks a capture made on the previous cycle.
//
// Optional feature macro: HA_CARRY_CNT_EN
//   defined   -> adds carry_cnt, a saturating count of captures with any carry
//   undefined -> carry_cnt port and counter are absent
//
// Ports:
//   S, C         out  WIDTH  combinational sum / carry
//   A, B         in   WIDTH  operands
//   clk          in   1      rising-edge clock for the registered stage
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      capture A/B on this clock edge
//   S_q, C_q     out  WIDTH  registered sum / carry
//   out_valid    out  1      S_q/C_q were captured on the previous edge
//   any_carry_q  out  1      registered OR of the carry lanes
//   carry_cnt    out  CNT_W  saturating carry-event count (HA_CARRY_CNT_EN only)

module half_adder_reg #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S_q,
  output logic [WIDTH-1:0] C_q,
  output logic             out_valid,
  output logic             any_carry_q
`ifdef HA_CARRY_CNT_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  // Elaboration-time guard on degenerate parameter values
  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("half_adder_reg: WIDTH and CNT_W must both be >= 1");
  end

  // Combinational lanes: pure functions of A and B
  assign S = A ^ B;
  assign C = A & B;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             valid_q, valid_d;
  logic             any_q, any_d;

  // Next-state: capture on in_valid, otherwise hold data and drop valid
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    any_d   = any_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = S;
      carry_d = C;
      any_d   = |C;
      valid_d = 1'b1;
    end
  end

  // Registered stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      any_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      any_q   <= any_d;
      valid_q <= valid_d;
    end
  end

  assign S_q         = sum_q;
  assign C_q         = carry_q;
  assign any_carry_q = any_q;
  assign out_valid   = valid_q;

`ifdef HA_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating increment: sticks at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|C) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder_reg.sv
// Self-checking bench for half_adder_reg: directed scenarios plus a randomized
// run against a lane-wise arithmetic reference model.
module tb_half_adder_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic [W-1:0] s, c, sq, cq;
  logic         ov, anyq;
`ifdef HA_CARRY_CNT_EN
  logic [CW-1:0] cnt;
`endif

  // Second, single-lane instance with clock and reset left floating
  logic a1, b1, s1, c1, sq1, cq1, ov1, any1;

  int vectors;
  int miscompares;

  // Reference model state
  logic [W-1:0] m_sq, m_cq;
  logic         m_v, m_any;
  int           m_cnt;

  half_adder_reg #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .S(s), .C(c), .A(a), .B(b),
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .S_q(sq), .C_q(cq), .out_valid(ov), .any_carry_q(anyq)
`ifdef HA_CARRY_CNT_EN
    , .carry_cnt(cnt)
`endif
  );

  half_adder_reg #(.WIDTH(1), .CNT_W(CW)) u_dut1 (
    .S(s1), .C(c1), .A(a1), .B(b1),
    .clk(1'bz), .rst_n(1'bz), .in_valid(1'b0),
    .S_q(sq1), .C_q(cq1), .out_valid(ov1), .any_carry_q(any1)
`ifdef HA_CARRY_CNT_EN
    , .carry_cnt()
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lane-wise arithmetic: a+b in {0,1,2}; sum is its low digit, carry its high
  function automatic logic [W-1:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) r[i] = ((int'(x[i]) + int'(y[i])) % 2) == 1;
    return r;
  endfunction

  function automatic logic [W-1:0] ref_carry(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) r[i] = ((int'(x[i]) + int'(y[i])) / 2) == 1;
    return r;
  endfunction

  task automatic model_reset();
    m_sq = '0; m_cq = '0; m_v = 1'b0; m_any = 1'b0; m_cnt = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".S_q"}, 32'(sq), 32'(m_sq));
    chk({tag, ".C_q"}, 32'(cq), 32'(m_cq));
    chk({tag, ".out_valid"}, 32'(ov), 32'(m_v));
    chk({tag, ".any_carry_q"}, 32'(anyq), 32'(m_any));
`ifdef HA_CARRY_CNT_EN
    chk({tag, ".carry_cnt"}, 32'(cnt), 32'(m_cnt));
`endif
  endtask

  // One clock cycle: drive at negedge, check comb, update model at posedge, check regs
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb);
    @(negedge clk);
    in_valid = v; a = ta; b = tb;
    #1;
    chk({tag, ".S"}, 32'(s), 32'(ref_sum(ta, tb)));
    chk({tag, ".C"}, 32'(c), 32'(ref_carry(ta, tb)));
    @(posedge clk);
    if (v) begin
      m_sq  = ref_sum(ta, tb);
      m_cq  = ref_carry(ta, tb);
      m_any = ref_carry(ta, tb) != '0;
      m_v   = 1'b1;
      if (m_any && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m_v = 1'b0;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [1:0] tt_exp [4];
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; a1 = 1'b0; b1 = 1'b0;
    model_reset();

    // Single-lane truth table on the floating-clock instance: {S,C}
    tt_exp[0] = 2'b00; tt_exp[1] = 2'b10; tt_exp[2] = 2'b10; tt_exp[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      a1 = (i & 2) != 0; b1 = (i & 1) != 0;
      #5;
      chk($sformatf("tt%0d", i), 32'({s1, c1}), 32'(tt_exp[i]));
    end

    // 8-lane combinational pattern
    a = 8'hF0; b = 8'h3C;
    #1;
    chk("comb_f0_3c.S", 32'(s), 32'h00CC);
    chk("comb_f0_3c.C", 32'(c), 32'h0030);

    // Reset state
    #1;
    check_regs("reset");
    chk("reset.S_q_const", 32'(sq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single capture, then hold
    cycle("cap_ff_01", 1'b1, 8'hFF, 8'h01);
    chk("cap_ff_01.S_q_const", 32'(sq), 32'h00FE);
    chk("cap_ff_01.C_q_const", 32'(cq), 32'h0001);
    chk("cap_ff_01.ov_const", 32'(ov), 32'h1);
    chk("cap_ff_01.any_const", 32'(anyq), 32'h1);
    cycle("hold", 1'b0, 8'h12, 8'h34);
    chk("hold.ov_const", 32'(ov), 32'h0);
    chk("hold.S_q_const", 32'(sq), 32'h00FE);

    // Mid-cycle asynchronous reset while out_valid is high
    cycle("pre_rst", 1'b1, 8'hF0, 8'h3C);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    a = 8'hAA; b = 8'h0F;
    #1;
    chk("async_rst.S", 32'(s), 32'h00A5);
    chk("async_rst.C", 32'(c), 32'h000A);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry counter saturation, then a carry-free capture
    for (int i = 0; i < 5; i++) begin
      cycle($sformatf("sat%0d", i), 1'b1, 8'h01, 8'h01);
`ifdef HA_CARRY_CNT_EN
      chk($sformatf("sat%0d.cnt_const", i), 32'(cnt), 32'((i < 3) ? i + 1 : 3));
`endif
    end
    cycle("no_carry", 1'b1, 8'hF0, 8'h0F);
    chk("no_carry.any_const", 32'(anyq), 32'h0);

    // Randomized run against the reference model
    for (int i = 0; i < 200; i++) begin
      cycle($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
